// File: rtl/video_ram_ctrl_pkg.sv
// video_ram_ctrl_pkg: shared types and constants for the video RAM controller.
//   fill_state_e : fill/clear engine state encoding (IDLE/FILL/DONE)
//   BYTE_W       : width of one memory byte lane
//   ZEROBYTE     : all-zero byte
//   ZEROWORD     : all-zero 32-bit word
package video_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] ZEROBYTE = '0;
    localparam logic [31:0] ZEROWORD = '0;

endpackage

// File: rtl/vram_byte_bank.sv
// vram_byte_bank: one 8-bit x 2**ADDR_W byte lane with one write port and two
// synchronous read ports (CPU and VGA).
//   clk        : clock, all activity on posedge
//   we         : write enable for this lane
//   waddr      : word address of the write
//   wdata      : byte to write
//   cpu_raddr  : CPU read word address, sampled every cycle
//   cpu_q      : CPU read data, one cycle after the address
//   vga_raddr  : VGA read word address, sampled every cycle
//   vga_q      : VGA read data, one cycle after the address
// Reads return the contents before a same-edge write (read-first).
module vram_byte_bank
    import video_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] cpu_raddr,
    output logic [BYTE_W-1:0] cpu_q,
    input  logic [ADDR_W-1:0] vga_raddr,
    output logic [BYTE_W-1:0] vga_q
);

    logic [BYTE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        cpu_q <= mem[cpu_raddr];
        vga_q <= mem[vga_raddr];
    end

endmodule

// File: rtl/video_ram_ctrl.sv
// video_ram_ctrl: byte-enabled CPU port, never-stalling VGA byte port and a
// hardware fill engine over a banked video RAM.
//   clk, rst_n       : clock (posedge) and asynchronous active-low reset
//   ce, we, addr     : CPU request valid, write/read, byte address
//   sel, data_i      : CPU write byte enables and data
//   data_o, ack      : CPU read data and one-cycle completion pulse
//   busy             : CPU requests are refused while the fill engine runs
//   vga_rdaddress    : VGA byte address, sampled every cycle
//   vga_q            : selected byte, two cycles after its address
//   vga_q_valid      : vga_q reflects an address sampled after reset
//   clr_start        : start a fill (sampled only when idle)
//   clr_value        : fill byte, latched on start
//   clr_done         : one-cycle pulse when the fill completes
module video_ram_ctrl
    import video_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                we,
    input  logic [ADDR_W+1:0]   addr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   data_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                ack,
    output logic                busy,
    input  logic [ADDR_W+1:0]   vga_rdaddress,
    output logic [7:0]          vga_q,
    output logic                vga_q_valid,
    input  logic                clr_start,
    input  logic [7:0]          clr_value,
    output logic                clr_done
);

    localparam int BYTES = DATA_W / BYTE_W;

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] fill_val_q, fill_val_d;
    logic              busy_q, busy_d;
    logic              clr_done_q, clr_done_d;
    logic              ack_q, ack_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic [1:0]        vga_off_q, vga_off_d;
    logic [1:0]        vga_valid_q, vga_valid_d;
    logic [BYTE_W-1:0] vga_q_q, vga_q_d;

    logic              accept, cpu_wr, filling;
    logic [BYTES-1:0]  bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] cpu_word;
    logic [BYTE_W-1:0] vga_bytes [BYTES];
    logic [1:0]        vga_idx;
    logic              unused_ok;

    assign unused_ok = ^addr[1:0];

    // busy is registered, so a request arriving with clr_start is still taken
    assign accept  = ce && !busy_q;
    assign cpu_wr  = accept && we;
    assign filling = (state_q == ST_FILL);

    // the fill engine owns the write port only while it is writing
    assign bank_we    = filling ? {BYTES{1'b1}} : (cpu_wr ? sel : '0);
    assign bank_waddr = filling ? cnt_q : addr[ADDR_W+1:2];
    assign bank_wdata = filling ? {BYTES{fill_val_q}} : data_i;

    for (genvar i = 0; i < BYTES; i++) begin : g_bank
        vram_byte_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clk       (clk),
            .we        (bank_we[i]),
            .waddr     (bank_waddr),
            .wdata     (bank_wdata[i*BYTE_W +: BYTE_W]),
            .cpu_raddr (addr[ADDR_W+1:2]),
            .cpu_q     (cpu_word[i*BYTE_W +: BYTE_W]),
            .vga_raddr (vga_rdaddress[ADDR_W+1:2]),
            .vga_q     (vga_bytes[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        busy_d     = busy_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d    = ST_FILL;
                    cnt_d      = '0;
                    fill_val_d = clr_value;
                    busy_d     = 1'b1;
                end
            end
            ST_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d    = ST_DONE;
                    clr_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // bank output byte 0 is the least significant lane
    always_comb begin
        vga_idx     = BIG_ENDIAN ? 2'(BYTES - 1) - vga_off_q : vga_off_q;
        vga_q_d     = vga_bytes[vga_idx];
        vga_off_d   = vga_rdaddress[1:0];
        vga_valid_d = {vga_valid_q[0], 1'b1};
        rd_pend_d   = accept && !we;
        ack_d       = cpu_wr || rd_pend_q;
        data_o_d    = rd_pend_q ? cpu_word : data_o_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_val_q  <= ZEROBYTE;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
            ack_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            data_o_q    <= '0;
            vga_off_q   <= '0;
            vga_valid_q <= '0;
            vga_q_q     <= ZEROBYTE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_val_q  <= fill_val_d;
            busy_q      <= busy_d;
            clr_done_q  <= clr_done_d;
            ack_q       <= ack_d;
            rd_pend_q   <= rd_pend_d;
            data_o_q    <= data_o_d;
            vga_off_q   <= vga_off_d;
            vga_valid_q <= vga_valid_d;
            vga_q_q     <= vga_q_d;
        end
    end

    assign data_o      = data_o_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign clr_done    = clr_done_q;
    assign vga_q       = vga_q_q;
    assign vga_q_valid = vga_valid_q[1];

endmodule

// File: tb/tb_video_ram_ctrl.sv
// tb_video_ram_ctrl: directed self-checking bench for video_ram_ctrl.
module tb_video_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ack;
    logic        busy;
    logic [11:0] vga_rdaddress = '0;
    logic [7:0]  vga_q;
    logic        vga_q_valid;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_value = '0;
    logic        clr_done;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] last_data = '0;
    int busy_cycles, done_cnt, ack_busy;

    video_ram_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .we            (we),
        .addr          (addr),
        .sel           (sel),
        .data_i        (data_i),
        .data_o        (data_o),
        .ack           (ack),
        .busy          (busy),
        .vga_rdaddress (vga_rdaddress),
        .vga_q         (vga_q),
        .vga_q_valid   (vga_q_valid),
        .clr_start     (clr_start),
        .clr_value     (clr_value),
        .clr_done      (clr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d;
        tick();
        ce = 1'b0; we = 1'b0;
        chk("wr_ack", {31'd0, ack}, 32'd1);
        chk("wr_data_hold", data_o, last_data);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        ce = 1'b1; we = 1'b0; addr = a;
        tick();
        ce = 1'b0;
        chk({tag, "_ack_early"}, {31'd0, ack}, 32'd0);
        tick();
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        chk(tag, data_o, exp);
        last_data = exp;
    endtask

    task automatic wait_fill(input int pulse_at);
        busy_cycles = 0; done_cnt = 0; ack_busy = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (clr_done) done_cnt++;
            if (ack) ack_busy++;
            clr_start = (i == pulse_at);
            clr_value = (i == pulse_at) ? 8'h99 : clr_value;
            tick();
        end
        clr_start = 1'b0;
        chk("fill_busy_cycles", busy_cycles, 32'd1025);
        chk("fill_done_pulses", done_cnt, 32'd1);
        chk("fill_no_ack", ack_busy, 32'd0);
        chk("fill_busy_low", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vga_q", {24'd0, vga_q}, 32'd0);
        chk("rst_vga_valid", {31'd0, vga_q_valid}, 32'd0);
        chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("vga_valid_0", {31'd0, vga_q_valid}, 32'd0);
        tick();
        chk("vga_valid_1", {31'd0, vga_q_valid}, 32'd0);
        tick();
        chk("vga_valid_2", {31'd0, vga_q_valid}, 32'd1);

        // basic write then read
        wr(12'h010, 4'b1111, 32'hA1B2C3D4);
        rd(12'h010, 32'hA1B2C3D4, "t1_rd");

        // byte enables
        wr(12'h010, 4'b1111, 32'h11223344);
        wr(12'h010, 4'b0101, 32'hFFFFFFFF);
        rd(12'h010, 32'h11FF33FF, "t2_rd");
        wr(12'h010, 4'b0000, 32'h00000000);
        rd(12'h010, 32'h11FF33FF, "t2_sel0");

        // VGA byte order, big-endian
        wr(12'h010, 4'b1111, 32'h11223344);
        vga_rdaddress = 12'h010;
        tick();
        vga_rdaddress = 12'h011;
        tick();
        chk("t3_vga0", {24'd0, vga_q}, 32'h11);
        vga_rdaddress = 12'h012;
        tick();
        chk("t3_vga1", {24'd0, vga_q}, 32'h22);
        vga_rdaddress = 12'h013;
        tick();
        chk("t3_vga2", {24'd0, vga_q}, 32'h33);
        tick();
        chk("t3_vga3", {24'd0, vga_q}, 32'h44);
        chk("t3_vga_valid", {31'd0, vga_q_valid}, 32'd1);

        // fill 0x20 with a CPU read held during busy
        clr_start = 1'b1; clr_value = 8'h20;
        tick();
        clr_start = 1'b0;
        ce = 1'b1; we = 1'b0; addr = 12'h008;
        wait_fill(-1);
        chk("t4_clr_done_low", {31'd0, clr_done}, 32'd0);
        tick();
        ce = 1'b0;
        chk("t4_ack_early", {31'd0, ack}, 32'd0);
        tick();
        chk("t4_held_ack", {31'd0, ack}, 32'd1);
        chk("t4_held_data", data_o, 32'h20202020);
        last_data = 32'h20202020;
        rd(12'h000, 32'h20202020, "t4_w0");
        rd(12'hFFC, 32'h20202020, "t4_wlast");
        rd(12'h010, 32'h20202020, "t4_w4");

        // reset in the middle of a fill
        wr(12'h018, 4'b1111, 32'hCAFEF00D);
        clr_start = 1'b1; clr_value = 8'h5A;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_done_rst", {31'd0, clr_done}, 32'd0);
        tick();
        rst_n = 1'b1;
        last_data = 32'd0;
        chk("t5_data_o_rst", data_o, 32'd0);
        tick();
        tick();
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_done_after", {31'd0, clr_done}, 32'd0);
        rd(12'h000, 32'h5A5A5A5A, "t5_w0");
        rd(12'h010, 32'h5A5A5A5A, "t5_w4");
        rd(12'h018, 32'hCAFEF00D, "t5_w6");

        // fill with a clr_start pulse mid-fill that must be ignored
        clr_start = 1'b1; clr_value = 8'h77;
        tick();
        clr_start = 1'b0;
        wait_fill(10);
        rd(12'h190, 32'h77777777, "t6_fill_w100");
        rd(12'h020, 32'h77777777, "t6_fill_w8");

        // VGA read vs CPU write to the same word: old data first
        vga_rdaddress = 12'h020;
        wr(12'h020, 4'b1111, 32'hABCDEF01);
        tick();
        chk("rf_vga_old", {24'd0, vga_q}, 32'h77);
        tick();
        chk("rf_vga_new", {24'd0, vga_q}, 32'hAB);

        // back-to-back reads
        wr(12'h024, 4'b1111, 32'h09090909);
        wr(12'h028, 4'b1111, 32'h10101010);
        wr(12'h02C, 4'b1111, 32'h11111111);
        ce = 1'b1; we = 1'b0; addr = 12'h020;
        tick();
        addr = 12'h024;
        chk("b2b_ack0", {31'd0, ack}, 32'd0);
        tick();
        addr = 12'h028;
        chk("b2b_ack1", {31'd0, ack}, 32'd1);
        chk("b2b_d1", data_o, 32'hABCDEF01);
        tick();
        addr = 12'h02C;
        chk("b2b_ack2", {31'd0, ack}, 32'd1);
        chk("b2b_d2", data_o, 32'h09090909);
        tick();
        ce = 1'b0;
        chk("b2b_ack3", {31'd0, ack}, 32'd1);
        chk("b2b_d3", data_o, 32'h10101010);
        tick();
        chk("b2b_ack4", {31'd0, ack}, 32'd1);
        chk("b2b_d4", data_o, 32'h11111111);
        tick();
        chk("b2b_ack_end", {31'd0, ack}, 32'd0);
        chk("b2b_hold", data_o, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
